// File: rtl/fp_mul_mantissa_seq_pkg.sv
// Shared binary32 definitions for the step-1 FP multiplier stage.
package fp_mul_mantissa_seq_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Denormals keep a hidden 0 and are not pre-normalised.
  function automatic logic [MANT_W-1:0] significand(input fp32_t x);
    return {|x.exp, x.frac};
  endfunction

  function automatic logic is_zero(input fp32_t x);
    return (x.exp == '0) && (x.frac == '0);
  endfunction

endpackage

// File: rtl/fp_mul_mantissa_seq_if.sv
// Request/result bundle between the step-1 multiplier and its neighbours.
interface fp_mul_mantissa_seq_if;
  import fp_mul_mantissa_seq_pkg::*;

  logic              start;
  fp32_t             op1;
  fp32_t             op2;
  logic              busy;
  logic              done;
  logic              sign1;
  logic              sign2;
  logic [EXP_W-1:0]  exp1;
  logic [EXP_W-1:0]  exp2;
  logic              carry;
  logic [FRAC_W-1:0] mant_out;
  logic              guard;
  logic              sticky;
  logic              zero;

  modport master (
    output start, op1, op2,
    input  busy, done, sign1, sign2, exp1, exp2, carry, mant_out, guard, sticky, zero
  );

  modport slave (
    input  start, op1, op2,
    output busy, done, sign1, sign2, exp1, exp2, carry, mant_out, guard, sticky, zero
  );

endinterface

// File: rtl/fp_mul_mantissa_seq_mant_shift_add_unit.sv
// One shift-add step: add multiplicand x low BPC multiplier bits into the
// upper accumulator half, then shift the whole accumulator right by BPC.
module fp_mul_mantissa_seq_mant_shift_add_unit #(
  parameter int MANT_W = fp_mul_mantissa_seq_pkg::MANT_W,
  parameter int BPC    = 1
) (
  input  logic [MANT_W-1:0]   i_mcand,
  input  logic [BPC-1:0]      i_mbits,
  input  logic [2*MANT_W-1:0] i_acc,
  output logic [2*MANT_W-1:0] o_acc
);

  localparam int ACC_W = 2 * MANT_W;
  localparam int SUM_W = MANT_W + BPC;

  logic [SUM_W-1:0]       w_pp;
  logic [SUM_W-1:0]       w_sum;
  logic [ACC_W+BPC-1:0]   w_wide;

  // The upper half stays below the multiplicand, so SUM_W bits never overflow.
  always_comb begin
    w_pp   = SUM_W'(i_mcand) * SUM_W'(i_mbits);
    w_sum  = SUM_W'(i_acc[ACC_W-1:MANT_W]) + w_pp;
    w_wide = {w_sum, i_acc[MANT_W-1:0]};
    o_acc  = ACC_W'(w_wide >> BPC);
  end

endmodule

// File: rtl/fp_mul_mantissa_seq.sv
// Step-1 FP multiplier: unpacks two binary32 operands, multiplies significands
// iteratively and presents the normalised fraction with guard/sticky/carry.
module fp_mul_mantissa_seq #(
  parameter int MANT_W = 24,
  parameter int BPC    = 1
) (
  input logic                  CLK,
  input logic                  RST,
  fp_mul_mantissa_seq_if.slave bus
);
  import fp_mul_mantissa_seq_pkg::*;

  localparam int ACC_W = 2 * MANT_W;
  localparam int NSTEP = MANT_W / BPC;
  localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_MUL  = 2'(MUL);
  localparam logic [1:0] S_DONE = 2'(DONE);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ACC_W-1:0]  r_acc;
  logic [MANT_W-1:0] r_mcand;
  logic [MANT_W-1:0] r_mplier;
  logic              r_sign1;
  logic              r_sign2;
  logic [EXP_W-1:0]  r_exp1;
  logic [EXP_W-1:0]  r_exp2;
  logic              r_zero;
  logic              r_carry;
  logic [FRAC_W-1:0] r_mant;
  logic              r_guard;
  logic              r_sticky;

  logic [ACC_W-1:0]  w_acc_next;
  logic              w_carry;
  logic [FRAC_W-1:0] w_mant;
  logic              w_guard;
  logic              w_sticky;

  fp_mul_mantissa_seq_mant_shift_add_unit #(
    .MANT_W (MANT_W),
    .BPC    (BPC)
  ) u_mant_shift_add_unit (
    .i_mcand (r_mcand),
    .i_mbits (r_mplier[BPC-1:0]),
    .i_acc   (r_acc),
    .o_acc   (w_acc_next)
  );

  // Normalise straight off the final step so results land with the DONE state.
  always_comb begin
    w_carry  = w_acc_next[ACC_W-1];
    w_mant   = w_acc_next[ACC_W-3 -: FRAC_W];
    w_guard  = w_acc_next[MANT_W-2];
    w_sticky = |w_acc_next[MANT_W-3:0];
    if (w_carry) begin
      w_mant   = w_acc_next[ACC_W-2 -: FRAC_W];
      w_guard  = w_acc_next[MANT_W-1];
      w_sticky = |w_acc_next[MANT_W-2:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_sign1  <= 1'b0;
      r_sign2  <= 1'b0;
      r_exp1   <= '0;
      r_exp2   <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_mant   <= '0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_sign1  <= bus.op1.sign;
            r_sign2  <= bus.op2.sign;
            r_exp1   <= bus.op1.exp;
            r_exp2   <= bus.op2.exp;
            r_zero   <= is_zero(bus.op1) | is_zero(bus.op2);
            r_mcand  <= significand(bus.op1);
            r_mplier <= significand(bus.op2);
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_MUL;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mplier <= r_mplier >> BPC;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(NSTEP - 1)) begin
            r_carry  <= w_carry;
            r_mant   <= w_mant;
            r_guard  <= w_guard;
            r_sticky <= w_sticky;
            r_state  <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.sign1    = r_sign1;
  assign bus.sign2    = r_sign2;
  assign bus.exp1     = r_exp1;
  assign bus.exp2     = r_exp2;
  assign bus.zero     = r_zero;
  assign bus.carry    = r_carry;
  assign bus.mant_out = r_mant;
  assign bus.guard    = r_guard;
  assign bus.sticky   = r_sticky;

endmodule

// File: tb/tb_fp_mul_mantissa_seq.sv
// Scoreboard bench for fp_mul_mantissa_seq: driver pushes model results,
// a negedge monitor pops them whenever done is seen.
module tb_fp_mul_mantissa_seq;

  localparam int LAT = 25;

  typedef struct {
    logic        s1;
    logic        s2;
    logic [7:0]  e1;
    logic [7:0]  e2;
    logic        c;
    logic [22:0] m;
    logic        g;
    logic        st;
    logic        z;
    int          doneCyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  int   busyLo;
  int   busyHi;
  logic [25:0] holdPrev;
  logic [25:0] holdCur;
  exp_t sb[$];

  fp_mul_mantissa_seq_if bus();

  fp_mul_mantissa_seq dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer product, then pick the fraction window by the top bit.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] ma;
    logic [63:0] mb;
    logic [63:0] p;
    int          sh;
    ma = (a[30:23] != 0) ? (64'd8388608 + 64'(a[22:0])) : 64'(a[22:0]);
    mb = (b[30:23] != 0) ? (64'd8388608 + 64'(b[22:0])) : 64'(b[22:0]);
    p  = ma * mb;
    e.s1 = a[31];
    e.s2 = b[31];
    e.e1 = a[30:23];
    e.e2 = b[30:23];
    e.c  = (p >= 64'h8000_0000_0000);
    sh   = e.c ? 24 : 23;
    e.m  = 23'((p >> sh) % 64'd8388608);
    e.g  = p[sh-1];
    e.st = (p % (64'd1 << (sh - 1))) != 0;
    e.z  = (a[30:0] == 0) || (b[30:0] == 0);
    e.doneCyc = 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Called just after a posedge with the DUT idle; returns one cycle later.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(a, b);
    e.doneCyc = cyc + LAT;
    sb.push_back(e);
    holdPrev = holdCur;
    holdCur  = {e.c, e.m, e.g, e.st};
    busyLo   = cyc + 1;
    busyHi   = cyc + LAT;
    bus.op1   = a;
    bus.op2   = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (cyc <= busyHi && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) checkOutput("idle_timeout", 64'(cyc), 64'(busyHi + 1));
  endtask

  task automatic runOp(input logic [31:0] a, input logic [31:0] b);
    applyStimulus(a, b);
    waitIdle();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      checkOutput("busy", 64'(bus.busy), 64'((cyc >= busyLo) && (cyc <= busyHi)));
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 64'(bus.done), 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("latency",  64'(cyc), 64'(e.doneCyc));
          checkOutput("sign_exp", 64'({bus.sign1, bus.sign2, bus.exp1, bus.exp2}),
                                  64'({e.s1, e.s2, e.e1, e.e2}));
          checkOutput("carry",    64'(bus.carry),    64'(e.c));
          checkOutput("mant_out", 64'(bus.mant_out), 64'(e.m));
          checkOutput("guard",    64'(bus.guard),    64'(e.g));
          checkOutput("sticky",   64'(bus.sticky),   64'(e.st));
          checkOutput("zero",     64'(bus.zero),     64'(e.z));
        end
      end else if (sb.size() > 0 && cyc > sb[0].doneCyc) begin
        checkOutput("done_timeout", 64'(bus.done), 64'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          t0;
    cyc = 0; checks = 0; failures = 0;
    busyLo = 1; busyHi = 0;
    holdPrev = '0; holdCur = '0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op1 = '0;
    bus.op2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_state", 64'({bus.busy, bus.done, bus.sign1, bus.sign2, bus.exp1, bus.exp2,
                                    bus.carry, bus.mant_out, bus.guard, bus.sticky, bus.zero}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    runOp(32'h3F80_0000, 32'h3F80_0000);
    runOp(32'h3FC0_0000, 32'h3FC0_0000);
    runOp(32'h3FFF_FFFF, 32'hBFFF_FFFF);
    runOp(32'h0000_0000, 32'h4049_0FDB);

    // A start pulse while busy must not disturb the operation in flight.
    t0 = cyc - 1;
    applyStimulus(32'h4000_0000, 32'h4040_0001);
    while (cyc < t0 + 5) begin @(posedge clk); #1; end
    bus.op1 = 32'hC120_0000;
    bus.op2 = 32'h8000_0000;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (cyc < t0 + 10) begin @(posedge clk); #1; end
    @(negedge clk);
    checkOutput("ignored_start_fields", 64'({bus.sign1, bus.sign2, bus.exp1, bus.exp2, bus.zero}),
                                        64'({1'b0, 1'b0, 8'h80, 8'h80, 1'b0}));
    checkOutput("result_hold", 64'({bus.carry, bus.mant_out, bus.guard, bus.sticky}), 64'(holdPrev));
    @(posedge clk); #1;
    waitIdle();

    // Reset mid-operation aborts it; nothing may complete.
    t0 = cyc - 1;
    applyStimulus(32'h4123_4567, 32'hC0FE_DCBA);
    while (cyc < t0 + 10) begin @(posedge clk); #1; end
    rst = 1'b1;
    busyHi = cyc;
    void'(sb.pop_back());
    holdCur = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_clears", 64'({bus.busy, bus.done, bus.sign1, bus.sign2, bus.exp1, bus.exp2,
                                     bus.carry, bus.mant_out, bus.guard, bus.sticky, bus.zero}), 64'd0);
    @(posedge clk); #1;
    runOp(32'h3FC0_0000, 32'h4049_0FDB);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a[30:23] = 8'h00;
      if ($urandom_range(0, 3) == 0) b[30:23] = 8'h00;
      if ($urandom_range(0, 9) == 0) a[30:0] = 31'h0;
      if ($urandom_range(0, 7) == 0) b[22:0] = 23'h7F_FFFF;
      runOp(a, b);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
